mudi_seq: RTL

MUDI_SEQ -- requirements
Module: mudi_seq

---
 rtl/mudi_pkg.sv | 32 +++
 rtl/mudi_div_step.sv | 21 ++
 rtl/mudi_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mudi_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states, default operand width and small op-decode helpers.
package mudi_pkg;

    localparam int unsigned MUDI_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mudi_state_e;

    // Ops whose operands are interpreted as two's complement
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    // Ops that run the restoring divider
    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mudi_div_step.sv
// One restoring-division step: compare the shifted partial remainder against
// the divisor, subtract when it fits and emit the quotient bit.
module mudi_div_step
    import mudi_pkg::*;
#(
    parameter int unsigned WIDTH = MUDI_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_c_o,
    output logic             qbit_c_o
);

    logic [WIDTH-1:0] diff;

    // Low bits suffice for the difference: when it fits it is below the divisor
    assign diff     = rem_i[WIDTH-1:0] - div_i;
    assign qbit_c_o = (rem_i >= {1'b0, div_i});
    assign rem_c_o  = qbit_c_o ? diff : rem_i[WIDTH-1:0];

endmodule

// File: rtl/mudi_seq.sv
// Sequential multiply/divide unit with architectural HI/LO registers.
// Radix-2 iteration on operand magnitudes, one FIX cycle for sign/accumulate.
// Define MUDI_MACC_EN to enable MADD/MSUB; otherwise ops 6/7 are no-ops.
module mudi_seq
    import mudi_pkg::*;
#(
    parameter int unsigned WIDTH = MUDI_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E_isStart,
    input  logic             E_cancel,
    input  logic [2:0]       MUDI_mudiOp,
    input  logic [WIDTH-1:0] MUDI_src1,
    input  logic [WIDTH-1:0] MUDI_src2,
    output logic             isBusy,
    output logic [WIDTH-1:0] MUDI_HI,
    output logic [WIDTH-1:0] MUDI_LO
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = 2 * WIDTH;

    mudi_state_e      state_q;
    logic [2:0]       op_q;
    logic             neg_a_q;
    logic             neg_b_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             launch_iter;
    logic             src_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] ds_rem;
    logic             ds_qbit;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [PW-1:0]    prod_mag;
    logic [PW-1:0]    prod_s;
    logic [PW-1:0]    acc_d;
    logic [WIDTH-1:0] fix_hi_d;
    logic [WIDTH-1:0] fix_lo_d;

    assign isBusy  = (state_q != ST_IDLE);
    assign MUDI_HI = hi_q;
    assign MUDI_LO = lo_q;

    // Which requested ops start an iterative operation
    always_comb begin
        launch_iter = 1'b0;
        case (MUDI_mudiOp)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: launch_iter = 1'b1;
`ifdef MUDI_MACC_EN
            OP_MADD, OP_MSUB:                   launch_iter = 1'b1;
`endif
            default:                            launch_iter = 1'b0;
        endcase
    end

    // Operand signs and magnitudes captured at launch
    assign src_signed = op_is_signed(MUDI_mudiOp);
    assign a_neg      = src_signed & MUDI_src1[WIDTH-1];
    assign b_neg      = src_signed & MUDI_src2[WIDTH-1];
    assign a_mag      = a_neg ? (WIDTH'(0) - MUDI_src1) : MUDI_src1;
    assign b_mag      = b_neg ? (WIDTH'(0) - MUDI_src2) : MUDI_src2;

    // Shift-add partial sum: high half plus multiplicand when the multiplier LSB is set
    assign mul_sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opa_q} : (WIDTH + 1)'(0));

    mudi_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i    ({rem_q, quo_q[WIDTH-1]}),
        .div_i    (opb_q),
        .rem_c_o  (ds_rem),
        .qbit_c_o (ds_qbit)
    );

    // Next partial state for one CALC iteration
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        if (op_is_div(op_q)) begin
            rem_d = ds_rem;
            quo_d = {quo_q[WIDTH-2:0], ds_qbit};
        end else begin
            rem_d = mul_sum[WIDTH:1];
            quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
        end
    end

    // Sign correction, divide-by-zero override and accumulate for the FIX cycle
    always_comb begin
        prod_mag = {rem_q, quo_q};
        prod_s   = (neg_a_q ^ neg_b_q) ? (PW'(0) - prod_mag) : prod_mag;
        acc_d    = prod_s;
`ifdef MUDI_MACC_EN
        if (op_q == OP_MADD) begin
            acc_d = {hi_q, lo_q} + prod_s;
        end else if (op_q == OP_MSUB) begin
            acc_d = {hi_q, lo_q} - prod_s;
        end
`endif
        fix_hi_d = acc_d[PW-1:WIDTH];
        fix_lo_d = acc_d[WIDTH-1:0];
        if (op_is_div(op_q)) begin
            if (opb_q == '0) begin
                fix_hi_d = neg_a_q ? (WIDTH'(0) - opa_q) : opa_q;
                fix_lo_d = '1;
            end else begin
                fix_hi_d = neg_a_q ? (WIDTH'(0) - rem_q) : rem_q;
                fix_lo_d = (neg_a_q ^ neg_b_q) ? (WIDTH'(0) - quo_q) : quo_q;
            end
        end
    end

    // Control FSM with operand, iteration and HI/LO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (E_isStart && !E_cancel) begin
                        if (launch_iter) begin
                            op_q    <= MUDI_mudiOp;
                            neg_a_q <= a_neg;
                            neg_b_q <= b_neg;
                            opa_q   <= a_mag;
                            opb_q   <= b_mag;
                            rem_q   <= '0;
                            quo_q   <= op_is_div(MUDI_mudiOp) ? a_mag : b_mag;
                            cnt_q   <= CW'(WIDTH);
                            state_q <= ST_CALC;
                        end else if (MUDI_mudiOp == OP_MTHI) begin
                            hi_q <= MUDI_src1;
                        end else if (MUDI_mudiOp == OP_MTLO) begin
                            lo_q <= MUDI_src1;
                        end
                    end
                end
                ST_CALC: begin
                    if (E_cancel) begin
                        state_q <= ST_IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_q <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    if (!E_cancel) begin
                        hi_q <= fix_hi_d;
                        lo_q <= fix_lo_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
